ioctl_upload_server: RTL and testbench
======================================

# ioctl_upload_server

Serves HPS upload requests (save-state/hiscore/NVRAM readback) over the hps_io ioctl upload channel. This is the read-direction counterpart of the ROM download path. It halts the game core through a pause handshake, answers each `ioctl_rd` strobe with a byte fetched from a fixed-latency core RAM read port, and stretches `ioctl_wait` while the fetch is in flight. It sits in the arcade top level between `hps_io` and the core's save RAM.

## Interface
- `AW`, 10: save-region address width; region depth is 2**AW bytes.
- `RD_LAT`, 2: core RAM read latency in cycles, from `mem_rd` to `mem_q` valid; range 1..7.
- `PAUSE_TIMEOUT`, 4096: maximum cycles to wait for `pause_ack`.

Ports (clock and reset first):
- `clk_sys`  in  1  system clock; the only clock in the block.
- `reset`  in  1  asynchronous, active-high reset.
- `ioctl_upload`  in  1  high while HPS upload is active.
- `ioctl_rd`  in  1  one-cycle read strobe from HPS.
- `ioctl_addr`  in  25  byte address of the read.
- `ioctl_din`  out  8  byte returned to HPS.
- `ioctl_wait`  out  1  stalls HPS.
- `pause_req`  out  1  requests the core to halt.
- `pause_ack`  in  1  core is halted.
- `mem_addr`  out  AW  core RAM read address.
- `mem_rd`  out  1  one-cycle RAM read strobe.
- `mem_q`  in  8  RAM read data.
- `busy`  out  1  high in any state other than IDLE.
- `err`  out  1  sticky error flag; cleared on entry to PAUSE.

## Operation
States are IDLE, PAUSE, READY, FETCH.

- **IDLE**
  - Rising edge of `ioctl_upload` moves to PAUSE.
  - `pause_req` is 0 and `ioctl_wait` is 0.
- **PAUSE**
  - `pause_req`=1 and `ioctl_wait`=1.
  - Moves to READY on `pause_ack`=1.
  - If `PAUSE_TIMEOUT` cycles pass without `pause_ack`, sets `err` and moves to READY anyway.
- **READY**
  - `pause_req` stays 1.
  - On `ioctl_rd`, `ioctl_addr` is latched.
  - If `ioctl_addr` < 2**AW: issue `mem_rd` and go to FETCH.
  - Otherwise (out-of-range): load `ioctl_din`=8'hFF, stay in READY, and do not access the RAM.
- **FETCH**
  - Counts `RD_LAT` cycles, then captures `mem_q` into `ioctl_din` and returns to READY.
  - An `ioctl_rd` arriving during FETCH is ignored and sets `err`.
- **Upload end:** a falling edge of `ioctl_upload` in any state returns to IDLE on the next edge.
  - An in-flight fetch is abandoned and `ioctl_din` keeps its last value.
  - `pause_req` and `ioctl_wait` are 0 from that edge onward.
- **`ioctl_wait` decode:** `ioctl_wait` = (state==PAUSE) | (state==FETCH) | (state==READY & `ioctl_rd` & in-range).
  - This is the only combinational output; it ensures wait is high in the strobe cycle itself.
- **Address truncation:** `mem_addr` = `ioctl_addr[AW-1:0]`; the upper bits are used only for the range check.

## Timing
- **Reset:** state IDLE. `ioctl_din`=0, `ioctl_wait`=0, `pause_req`=0, `mem_addr`=0, `mem_rd`=0, `busy`=0, `err`=0. Reset mid-upload behaves the same; no further `mem_rd` is issued.
- **Upload start:** `ioctl_upload` rises at T. State is PAUSE and `pause_req`=1 from T+1. `pause_ack` seen at cycle A puts the block in READY at A+1.
- **In-range read:** `ioctl_rd` at T.
  - `ioctl_wait`=1 from T through T+1+RD_LAT.
  - `mem_rd`=1 and `mem_addr` valid at T+1 only.
  - `mem_q` is sampled at the end of T+1+RD_LAT.
  - `ioctl_din` is valid and `ioctl_wait`=0 at T+2+RD_LAT.
- **Out-of-range read:** `ioctl_rd` at T gives `ioctl_din`=8'hFF from T+1. `ioctl_wait` is never asserted.
- **Back-to-back reads:** a new `ioctl_rd` is accepted in the first cycle that `ioctl_wait`=0 (T+2+RD_LAT).
- **Simultaneous events:** `ioctl_rd` coinciding with the upload falling edge is dropped.
- **Timeout counter:** 13-bit, saturating.

## Structure
- Package `ioctl_upload_pkg` holds:
  - the state enum `upl_state_t` (IDLE, PAUSE, READY, FETCH);
  - `OOR_FILL` = 8'hFF;
  - the `ioctl_addr` width constant, 25.
- One sub-module, `pause_handshake`, contains the `pause_req`/`pause_ack` handshake plus the timeout counter. It outputs `granted` and `timed_out`.
- The `ioctl_upload` edge detector and the FETCH latency counter (3 bits) live in the top.

## Test plan
- **Reset mid-upload:** assert `reset` during FETCH -> all outputs 0 immediately; no `mem_rd` afterwards.
- **Normal read, RD_LAT=2:** upload start, `pause_ack` after 5 cycles, `ioctl_rd` at `ioctl_addr`=0x003 with RAM[3]=0xA5 -> `mem_rd` at T+1 with `mem_addr`=3, `ioctl_wait` high T..T+3, `ioctl_din`=0xA5 at T+4.
- **Sequential sweep:** read addresses 0..1023 of a RAM preloaded with addr^0x5A -> all bytes match; `err`=0.
- **Out-of-range:** `ioctl_addr`=0x400 with AW=10 -> `ioctl_din`=0xFF at T+1, no `mem_rd`, `ioctl_wait` stays 0.
- **Pause timeout:** `pause_ack` held 0 -> `err`=1 and READY after 4096 cycles; a subsequent read still returns correct data.
- **Abort:** `ioctl_upload` falls during FETCH -> IDLE next cycle, `pause_req`=0, `ioctl_wait`=0, `ioctl_din` unchanged.

Source files
------------

// File: rtl/ioctl_upload_pkg.sv
// Shared types and constants for the ioctl upload (HPS readback) server.
package ioctl_upload_pkg;
    localparam int         IOCTL_AW = 25;
    localparam logic [7:0] OOR_FILL = 8'hFF;

    typedef enum logic [1:0] {
        IDLE,
        PAUSE,
        READY,
        FETCH
    } upl_state_t;
endpackage

// File: rtl/ioctl_upload_server_pause_handshake.sv
// Core halt handshake: holds pause_req while an upload session is live and
// flags a timeout if the core never acknowledges.
module pause_handshake #(
    parameter int PAUSE_TIMEOUT = 4096
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic hold,
    input  logic active,
    input  logic pause_ack,
    output logic pause_req,
    output logic granted,
    output logic timed_out
);
    logic [12:0] cnt;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            pause_req <= 1'b0;
            cnt       <= '0;
        end else begin
            pause_req <= hold;
            if (!active)
                cnt <= '0;
            else if (cnt != '1)
                cnt <= cnt + 13'd1;
        end
    end

    assign granted   = active & pause_ack;
    // Fires on the last permitted PAUSE cycle so READY follows exactly PAUSE_TIMEOUT cycles in.
    assign timed_out = active & (cnt >= 13'(PAUSE_TIMEOUT - 1));
endmodule

// File: rtl/ioctl_upload_server.sv
// Answers HPS ioctl upload reads from a fixed-latency core RAM port while the
// core is held paused.
module ioctl_upload_server
    import ioctl_upload_pkg::*;
#(
    parameter int AW            = 10,
    parameter int RD_LAT        = 2,
    parameter int PAUSE_TIMEOUT = 4096
) (
    input  logic                clk_sys,
    input  logic                reset,
    input  logic                ioctl_upload,
    input  logic                ioctl_rd,
    input  logic [IOCTL_AW-1:0] ioctl_addr,
    output logic [7:0]          ioctl_din,
    output logic                ioctl_wait,
    output logic                pause_req,
    input  logic                pause_ack,
    output logic [AW-1:0]       mem_addr,
    output logic                mem_rd,
    input  logic [7:0]          mem_q,
    output logic                busy,
    output logic                err
);
    upl_state_t state, state_nxt;
    logic       upl_d, rise, fall;
    logic [2:0] lat_cnt;
    logic       granted, timed_out, in_range, lat_done;
    logic       issue, oor, capture, set_err, clr_err;

    assign rise     = ioctl_upload & ~upl_d;
    assign fall     = ~ioctl_upload & upl_d;
    assign in_range = (ioctl_addr[IOCTL_AW-1:AW] == '0);
    assign lat_done = (lat_cnt == 3'(RD_LAT));

    pause_handshake #(.PAUSE_TIMEOUT(PAUSE_TIMEOUT)) u_pause (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .hold      (state_nxt != IDLE),
        .active    (state == PAUSE),
        .pause_ack (pause_ack),
        .pause_req (pause_req),
        .granted   (granted),
        .timed_out (timed_out)
    );

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (state != IDLE && fall) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:  if (rise) state_nxt = PAUSE;
                PAUSE: if (granted || timed_out) state_nxt = READY;
                READY: if (ioctl_rd && in_range) state_nxt = FETCH;
                FETCH: if (lat_done) state_nxt = READY;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        issue      = (state == READY) & ioctl_rd & in_range & ~fall;
        oor        = (state == READY) & ioctl_rd & ~in_range & ~fall;
        capture    = (state == FETCH) & lat_done & ~fall;
        set_err    = ((state == PAUSE) & timed_out & ~pause_ack & ~fall) |
                     ((state == FETCH) & ioctl_rd);
        clr_err    = (state == IDLE) & rise;
        // Wait must already be high in the strobe cycle, hence the combinational term.
        ioctl_wait = (state == PAUSE) | (state == FETCH) |
                     ((state == READY) & ioctl_rd & in_range);
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            upl_d     <= 1'b0;
            lat_cnt   <= '0;
            ioctl_din <= '0;
            mem_addr  <= '0;
            mem_rd    <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b0;
        end else begin
            upl_d  <= ioctl_upload;
            busy   <= (state_nxt != IDLE);
            mem_rd <= issue;
            if (issue) begin
                mem_addr <= ioctl_addr[AW-1:0];
                lat_cnt  <= '0;
            end else if (state == FETCH) begin
                lat_cnt <= lat_cnt + 3'd1;
            end
            if (oor)          ioctl_din <= OOR_FILL;
            else if (capture) ioctl_din <= mem_q;
            if (clr_err)      err <= 1'b0;
            else if (set_err) err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_ioctl_upload_server.sv
// Directed bench for ioctl_upload_server with a latency-accurate RAM model.
module tb_ioctl_upload_server;
    localparam int AW     = 10;
    localparam int RD_LAT = 2;
    localparam int PTO    = 4096;

    logic          clk_sys = 1'b0;
    logic          reset = 1'b0;
    logic          ioctl_upload = 1'b0;
    logic          ioctl_rd = 1'b0;
    logic [24:0]   ioctl_addr = '0;
    logic [7:0]    ioctl_din;
    logic          ioctl_wait;
    logic          pause_req;
    logic          pause_ack = 1'b0;
    logic [AW-1:0] mem_addr;
    logic          mem_rd;
    logic [7:0]    mem_q;
    logic          busy;
    logic          err;

    int n_cmp = 0;
    int n_err = 0;
    int pulses = 0;

    logic [7:0] ram [1024];
    logic [7:0] pipe [RD_LAT];

    ioctl_upload_server #(.AW(AW), .RD_LAT(RD_LAT), .PAUSE_TIMEOUT(PTO)) dut (
        .clk_sys      (clk_sys),
        .reset        (reset),
        .ioctl_upload (ioctl_upload),
        .ioctl_rd     (ioctl_rd),
        .ioctl_addr   (ioctl_addr),
        .ioctl_din    (ioctl_din),
        .ioctl_wait   (ioctl_wait),
        .pause_req    (pause_req),
        .pause_ack    (pause_ack),
        .mem_addr     (mem_addr),
        .mem_rd       (mem_rd),
        .mem_q        (mem_q),
        .busy         (busy),
        .err          (err)
    );

    always #5 clk_sys = ~clk_sys;

    // Data appears RD_LAT cycles after the mem_rd cycle; zero when no read was issued.
    always @(posedge clk_sys) begin
        pipe[0] <= mem_rd ? ram[mem_addr] : 8'h00;
        for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
        if (mem_rd) pulses <= pulses + 1;
    end
    assign mem_q = pipe[RD_LAT-1];

    typedef struct {
        logic [24:0] addr;
        logic [7:0]  din;
        bit          inr;
    } vec_t;
    vec_t tbl [8];

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " din"}, 32'(ioctl_din), 0);
        chk({tag, " wait"}, 32'(ioctl_wait), 0);
        chk({tag, " pause_req"}, 32'(pause_req), 0);
        chk({tag, " mem_addr"}, 32'(mem_addr), 0);
        chk({tag, " mem_rd"}, 32'(mem_rd), 0);
        chk({tag, " busy"}, 32'(busy), 0);
        chk({tag, " err"}, 32'(err), 0);
    endtask

    // Raises upload in the current cycle; acks after ack_after PAUSE cycles.
    task automatic start_upload(input int ack_after);
        ioctl_upload = 1'b1;
        #1;
        chk("start pause_req@T", 32'(pause_req), 0);
        tick(); #1;
        chk("start pause_req@T+1", 32'(pause_req), 1);
        chk("start busy@T+1", 32'(busy), 1);
        chk("start wait@T+1", 32'(ioctl_wait), 1);
        for (int k = 1; k < ack_after; k++) tick();
        pause_ack = 1'b1;
        tick(); #1;
        pause_ack = 1'b0;
        chk("start wait@ready", 32'(ioctl_wait), 0);
        chk("start pause_req@ready", 32'(pause_req), 1);
    endtask

    task automatic do_read(input logic [24:0] a, input logic [7:0] exp, input bit inr, input string tag);
        logic [9:0] a_lo;
        a_lo = a[9:0];
        ioctl_addr = a;
        ioctl_rd   = 1'b1;
        #1;
        chk({tag, " wait@T"}, 32'(ioctl_wait), 32'(inr));
        tick();
        ioctl_rd = 1'b0;
        #1;
        if (inr) begin
            chk({tag, " mem_rd@T+1"}, 32'(mem_rd), 1);
            chk({tag, " mem_addr@T+1"}, 32'(mem_addr), 32'(a_lo));
            chk({tag, " wait@T+1"}, 32'(ioctl_wait), 1);
            for (int k = 2; k <= RD_LAT + 1; k++) begin
                tick(); #1;
                chk({tag, " wait@fetch"}, 32'(ioctl_wait), 1);
                chk({tag, " mem_rd@fetch"}, 32'(mem_rd), 0);
            end
            tick(); #1;
            chk({tag, " din"}, 32'(ioctl_din), 32'(exp));
            chk({tag, " wait@done"}, 32'(ioctl_wait), 0);
        end else begin
            chk({tag, " din"}, 32'(ioctl_din), 32'(exp));
            chk({tag, " mem_rd"}, 32'(mem_rd), 0);
            chk({tag, " wait@T+1"}, 32'(ioctl_wait), 0);
        end
    endtask

    initial begin
        int p0;
        logic [7:0] d0;
        for (int i = 0; i < 1024; i++) ram[i] = 8'(i) ^ 8'h5A;
        ram[3] = 8'hA5;
        tbl[0] = '{25'h0000003,  8'hA5, 1'b1};
        tbl[1] = '{25'h0000400,  8'hFF, 1'b0};
        tbl[2] = '{25'h0000000,  8'h5A, 1'b1};
        tbl[3] = '{25'h1000000,  8'hFF, 1'b0};
        tbl[4] = '{25'h00003FF,  8'hA5, 1'b1};
        tbl[5] = '{25'h0000155,  8'h0F, 1'b1};
        tbl[6] = '{25'h00007FF,  8'hFF, 1'b0};
        tbl[7] = '{25'h0000200,  8'h5A, 1'b1};

        #1 reset = 1'b1;
        #1 chk_all_zero("reset");
        tick(); tick();
        reset = 1'b0;
        tick(); #1;

        start_upload(5);
        for (int i = 0; i < 8; i++) do_read(tbl[i].addr, tbl[i].din, tbl[i].inr, $sformatf("vec%0d", i));

        // Full sweep with default contents
        ram[3] = 8'h59;
        for (int a = 0; a < 1024; a++) do_read(25'(a), 8'(a) ^ 8'h5A, 1'b1, "sweep");
        chk("sweep err", 32'(err), 0);

        // Strobe during FETCH: ignored, flags err, original read completes
        p0 = pulses;
        ioctl_addr = 25'h5; ioctl_rd = 1'b1;
        tick();
        ioctl_addr = 25'h6;
        tick(); ioctl_rd = 1'b0; #1;
        chk("rd_in_fetch err", 32'(err), 1);
        tick(); tick(); #1;
        chk("rd_in_fetch din", 32'(ioctl_din), 32'h5F);
        chk("rd_in_fetch wait", 32'(ioctl_wait), 0);
        chk("rd_in_fetch pulses", 32'(pulses - p0), 1);

        // Abort: upload falls while fetching addr 7
        d0 = ioctl_din;
        ioctl_addr = 25'h7; ioctl_rd = 1'b1;
        tick(); ioctl_rd = 1'b0;
        ioctl_upload = 1'b0;
        tick(); #1;
        chk("abort busy", 32'(busy), 0);
        chk("abort pause_req", 32'(pause_req), 0);
        chk("abort wait", 32'(ioctl_wait), 0);
        chk("abort din", 32'(ioctl_din), 32'(d0));
        p0 = pulses;
        for (int k = 0; k < 5; k++) tick();
        chk("abort pulses", 32'(pulses - p0), 0);
        chk("abort din later", 32'(ioctl_din), 32'(d0));

        // Pause timeout: err cleared on entry, then set when READY is forced
        ioctl_upload = 1'b1;
        tick(); #1;
        chk("tmo err cleared", 32'(err), 0);
        for (int k = 1; k < PTO; k++) tick();
        #1;
        chk("tmo wait@last", 32'(ioctl_wait), 1);
        chk("tmo err@last", 32'(err), 0);
        tick(); #1;
        chk("tmo wait@ready", 32'(ioctl_wait), 0);
        chk("tmo err@ready", 32'(err), 1);
        chk("tmo pause_req", 32'(pause_req), 1);
        do_read(25'h10, 8'h4A, 1'b1, "tmo read");

        // Strobe coinciding with the upload falling edge is dropped
        p0 = pulses;
        ioctl_addr = 25'h9; ioctl_rd = 1'b1; ioctl_upload = 1'b0;
        tick(); ioctl_rd = 1'b0; #1;
        chk("drop mem_rd", 32'(mem_rd), 0);
        chk("drop busy", 32'(busy), 0);
        tick(); tick(); #1;
        chk("drop pulses", 32'(pulses - p0), 0);
        chk("drop din", 32'(ioctl_din), 32'h4A);

        // Reset in the middle of a fetch
        start_upload(2);
        ioctl_addr = 25'h20; ioctl_rd = 1'b1;
        tick(); ioctl_rd = 1'b0; #1;
        chk("rst pre mem_rd", 32'(mem_rd), 1);
        reset = 1'b1; ioctl_upload = 1'b0;
        #1 chk_all_zero("rst mid");
        tick(); tick();
        reset = 1'b0;
        p0 = pulses;
        for (int k = 0; k < 6; k++) tick();
        chk("rst pulses", 32'(pulses - p0), 0);
        chk("rst busy", 32'(busy), 0);
        chk("rst din", 32'(ioctl_din), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
